// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encoding
// and operation select constants.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder cell: sum and carry-out of three input bits.
module fulladder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial N-bit adder/subtractor, LSB first through one full-adder cell.
// Optional signed-overflow output enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         cout,
`ifdef SERIAL_ADDSUB_OVF_EN
  output logic         ovf,
`endif
  output state_t       dbg_state
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] TC = CW'(N - 1);

  // Handshake: a request is accepted on any rising edge where start is high
  // and the FSM is in IDLE or DONE; start seen during RUN is dropped.

  state_t        r_state;
  state_t        w_next;
  logic          w_accept;
  logic          w_last;

  logic [N-1:0]  r_sa;
  logic [N-1:0]  r_sb;
  logic          r_carry;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_res;
  logic          r_cout;
  logic          r_busy;
  logic          r_done;
  logic          w_s;
  logic          w_c;

`ifdef SERIAL_ADDSUB_OVF_EN
  logic          r_cin_msb;
`endif

  fulladder u_fa (
    .i_a (r_sa[0]),
    .i_b (r_sb[0]),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_c)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        if (r_cnt == TC) begin
          w_last = 1'b1;
          w_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1: invert B on load and seed the carry with 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_busy <= (w_next == RUN);
      r_done <= (w_next == DONE);
      if (w_accept) begin
        r_sa    <= a;
        r_sb    <= b ^ {N{sub == OP_SUB}};
        r_carry <= (sub == OP_SUB);
        r_cnt   <= '0;
        r_res   <= '0;
      end else if (r_state == RUN) begin
        r_res   <= {w_s, r_res[N-1:1]};
        r_sa    <= {1'b0, r_sa[N-1:1]};
        r_sb    <= {1'b0, r_sb[N-1:1]};
        r_carry <= w_c;
        r_cnt   <= r_cnt + CW'(1);
        if (w_last) r_cout <= w_c;
      end
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  // Carry entering the MSB stage; XOR with the final carry gives signed overflow.
  always_ff @(posedge clk) begin
    if (rst)                           r_cin_msb <= 1'b0;
    else if (r_state == RUN && w_last) r_cin_msb <= r_carry;
  end

  assign ovf = r_cin_msb ^ r_cout;
`endif

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_res;
  assign cout      = r_cout;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (N = 8): directed cases, request
// drop during RUN, back-to-back issue, reset abort, and random operations.
module tb_serial_addsub;
  import addsub_pkg::*;

  localparam int N = 8;
  localparam int W = N + 2;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         cout;
  state_t       dbg_state;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic         ovf;
`endif

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;
  int n_checks;
  int n_errors;

  serial_addsub #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .cout      (cout),
`ifdef SERIAL_ADDSUB_OVF_EN
    .ovf       (ovf),
`endif
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model from plain integer arithmetic: {ovf, cout, result}.
  function automatic logic [W-1:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                         input logic s);
    int ua, ub, r, sx, sy, sr;
    logic [N-1:0] res;
    logic c_m, o_m;
    ua = int'(x);
    ub = int'(y);
    sx = x[N-1] ? ua - (1 << N) : ua;
    sy = y[N-1] ? ub - (1 << N) : ub;
    if (s == OP_SUB) begin
      r   = ua - ub;
      c_m = (ua >= ub);
      sr  = sx - sy;
    end else begin
      r   = ua + ub;
      c_m = (r >= (1 << N));
      sr  = sx + sy;
    end
    res = r[N-1:0];
    o_m = (sr > (1 << (N - 1)) - 1) || (sr < -(1 << (N - 1)));
    return {o_m, c_m, res};
  endfunction

  // Driver: call just after a negedge; returns at the negedge after acceptance.
  task automatic launch(input logic [N-1:0] x, input logic [N-1:0] y, input logic s,
                        input bit keep);
    a     = x;
    b     = y;
    sub   = s;
    start = 1'b1;
    exp_q.push_back(model(x, y, s));
    @(negedge clk);
    if (!keep) start = 1'b0;
    a   = N'($urandom);
    b   = N'($urandom);
    sub = 1'($urandom_range(0, 1));
  endtask

  // Waits (bounded) for done; cyc0 = cycles already elapsed since acceptance.
  task automatic wait_done(input string tag, input int cyc0);
    int cyc;
    logic [W-1:0] e;
    cyc = cyc0;
    while (done !== 1'b1 && cyc < N + 4) begin
      check({tag, " busy"}, 32'(busy), 32'd1);
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(N));
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    check({tag, " queue"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      last_exp = e;
      check({tag, " result"}, 32'(result), 32'(e[N-1:0]));
      check({tag, " cout"}, 32'(cout), 32'(e[N]));
`ifdef SERIAL_ADDSUB_OVF_EN
      check({tag, " ovf"}, 32'(ovf), 32'(e[N+1]));
`endif
    end
  endtask

  task automatic check_idle_hold(input string tag);
    @(negedge clk);
    check({tag, " idle_busy"}, 32'(busy), 32'd0);
    check({tag, " idle_done"}, 32'(done), 32'd0);
    check({tag, " idle_state"}, 32'(dbg_state), 32'(IDLE));
    check({tag, " hold_result"}, 32'(result), 32'(last_exp[N-1:0]));
    check({tag, " hold_cout"}, 32'(cout), 32'(last_exp[N]));
  endtask

  task automatic check_zero(input string tag);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " result"}, 32'(result), 32'd0);
    check({tag, " cout"}, 32'(cout), 32'd0);
    check({tag, " state"}, 32'(dbg_state), 32'(IDLE));
`ifdef SERIAL_ADDSUB_OVF_EN
    check({tag, " ovf"}, 32'(ovf), 32'd0);
`endif
  endtask

  initial begin
    int n_done;
    n_checks = 0;
    n_errors = 0;
    last_exp = '0;
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed arithmetic cases
    launch(8'h05, 8'h03, OP_ADD, 1'b0); wait_done("add_5_3", 0);
    check("add_5_3 const", 32'(result), 32'h08);
    check_idle_hold("add_5_3");
    launch(8'h05, 8'h03, OP_SUB, 1'b0); wait_done("sub_5_3", 0);
    check("sub_5_3 const", 32'(result), 32'h02);
    launch(8'h03, 8'h05, OP_SUB, 1'b0); wait_done("sub_3_5", 0);
    check("sub_3_5 const", 32'({cout, result}), 32'h0FE);
    launch(8'hFF, 8'h01, OP_ADD, 1'b0); wait_done("add_ff_1", 0);
    check("add_ff_1 const", 32'({cout, result}), 32'h100);
    launch(8'h7F, 8'h01, OP_ADD, 1'b0); wait_done("add_7f_1", 0);
    check("add_7f_1 const", 32'({cout, result}), 32'h080);
`ifdef SERIAL_ADDSUB_OVF_EN
    check("add_7f_1 ovf_const", 32'(ovf), 32'd1);
`endif
    check_idle_hold("add_7f_1");

    // Requests during RUN are dropped
    launch(8'h21, 8'h13, OP_ADD, 1'b0);
    @(negedge clk);
    start = 1'b1; a = 8'hAA; b = 8'h55; sub = OP_SUB;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 8'h0F; b = 8'hF0; sub = OP_ADD;
    @(negedge clk);
    start = 1'b0;
    wait_done("run_ignore", 4);
    check_idle_hold("run_ignore");
    check("run_ignore queue_empty", 32'(exp_q.size()), 32'd0);

    // Back-to-back with start held through DONE: done every N+1 cycles
    launch(8'h11, 8'h22, OP_ADD, 1'b1); wait_done("b2b_0", 0);
    launch(8'h90, 8'h91, OP_SUB, 1'b1); wait_done("b2b_1", 0);
    launch(8'hC0, 8'h50, OP_ADD, 1'b0); wait_done("b2b_2", 0);
    check_idle_hold("b2b_2");

    // Reset in the middle of a subtraction discards it
    launch(8'h55, 8'h21, OP_SUB, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("rst_mid");
    rst = 1'b0;
    exp_q.delete();
    n_done = 0;
    repeat (N + 2) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    check("rst_mid no_done", 32'(n_done), 32'd0);
    launch(8'h10, 8'h20, OP_ADD, 1'b0); wait_done("post_rst", 0);
    check("post_rst const", 32'(result), 32'h30);

    // Reset wins over start in the same cycle
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 8'h01; b = 8'h02; sub = OP_ADD;
    @(negedge clk);
    check("rst_start busy", 32'(busy), 32'd0);
    check("rst_start state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start busy2", 32'(busy), 32'd0);

    // Random operations with random gaps (gap 0 issues straight from DONE)
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      launch(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      wait_done("rand", 0);
    end
    check_idle_hold("rand_end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
